dmem_wait_ctrl: RTL

- Parametrised successor to the single-cycle data memory in the five-stage RISC-V pipeline.
- Adds a configurable wait-state count, byte-lane sub-word access with sign/zero extension, and misalignment detection.
- Provides a stall/done handshake to the MEM stage.
- Sits between RiscvCore's data port and the on-chip data RAM array, which is held inside this block.

---
 rtl/riscv_mem_pkg.sv | 25 ++
 rtl/dmem_wait_ctrl_if.sv | 24 ++
 rtl/dmem_lane_align.sv | 46 ++++
 rtl/dmem_wait_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the wait-state data memory: MemOp codes, FSM states, alignment rule.
package riscv_mem_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2
  } memState_e;

  // Unlisted funct3 codes behave as word accesses.
  function automatic logic mem_misaligned(input logic [2:0] op, input logic [1:0] a);
    case (op)
      MEMOP_B, MEMOP_BU: return 1'b0;
      MEMOP_H, MEMOP_HU: return a[0];
      default:           return a != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dmem_wait_ctrl_if.sv
// Core-to-data-memory port: request/stall/done handshake plus data buses.
interface dmem_wait_ctrl_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              MemRead;
  logic              MemWrite;
  logic [2:0]        MemOp;
  logic [ADDR_W-1:0] DataAddr;
  logic [31:0]       WriteData;
  logic [31:0]       MemReadDataOut;
  logic              MemStall;
  logic              MemDone;
  logic              MisalignErr;

  modport master (
    output MemRead, MemWrite, MemOp, DataAddr, WriteData,
    input  MemReadDataOut, MemStall, MemDone, MisalignErr
  );

  modport slave (
    input  MemRead, MemWrite, MemOp, DataAddr, WriteData,
    output MemReadDataOut, MemStall, MemDone, MisalignErr
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store lane mask and data replication, load extraction and extension.
module dmem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  a,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  laneMask,
  output logic [31:0] wdataRep,
  output logic [31:0] rdataExt
);

  logic [31:0] shifted;

  always_comb begin
    shifted  = rword >> {a, 3'b000};
    laneMask = 4'hF;
    wdataRep = wdata;
    rdataExt = shifted;
    case (op)
      MEMOP_B: begin
        laneMask = 4'b0001 << a;
        wdataRep = {4{wdata[7:0]}};
        rdataExt = {{24{shifted[7]}}, shifted[7:0]};
      end
      MEMOP_BU: begin
        laneMask = 4'b0001 << a;
        wdataRep = {4{wdata[7:0]}};
        rdataExt = {24'd0, shifted[7:0]};
      end
      MEMOP_H: begin
        laneMask = 4'b0011 << a;
        wdataRep = {2{wdata[15:0]}};
        rdataExt = {{16{shifted[15]}}, shifted[15:0]};
      end
      MEMOP_HU: begin
        laneMask = 4'b0011 << a;
        wdataRep = {2{wdata[15:0]}};
        rdataExt = {16'd0, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_wait_ctrl.sv
// Data memory with programmable wait states, sub-word access and misalignment rejection.
module dmem_wait_ctrl
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned ADDR_W      = 32
) (
  input logic             clk,
  input logic             reset,
  dmem_wait_ctrl_if.slave bus
);

  localparam int unsigned IdxW    = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

  memState_e       stateQ, stateD;
  logic [3:0]      cntQ, cntD;
  logic [IdxW+1:0] addrQ, addrEff;
  logic [2:0]      opQ, opEff;
  logic [31:0]     wdataQ, wdataEff;
  logic            writeQ, writeEff, rejQ, rejEff;
  logic [31:0]     rdataQ;
  logic            inIdle, anyReq, illegal, access;
  logic [3:0]      laneMask;
  logic [31:0]     wdataRep, rdataExt, rword;
  logic [31:0]     mem [DEPTH_WORDS];
  logic [ADDR_W-1:0] dataAddr;

  assign dataAddr = bus.DataAddr;
  generate
    if (ADDR_W > IdxW + 2) begin : gen_unused_addr
      logic unusedAddrBits;
      assign unusedAddrBits = ^dataAddr[ADDR_W-1:IdxW+2];
    end
  endgenerate

  assign inIdle  = stateQ == StIdle;
  assign anyReq  = bus.MemRead | bus.MemWrite;
  assign illegal = bus.MemRead & bus.MemWrite;

  // With zero latency the access happens on the acceptance edge, so bypass the capture regs.
  always_comb begin
    addrEff  = addrQ;
    opEff    = opQ;
    wdataEff = wdataQ;
    writeEff = writeQ;
    rejEff   = rejQ;
    if (inIdle) begin
      addrEff  = dataAddr[IdxW+1:0];
      opEff    = bus.MemOp;
      wdataEff = bus.WriteData;
      writeEff = bus.MemWrite;
      rejEff   = illegal | mem_misaligned(bus.MemOp, dataAddr[1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stateQ <= StIdle;
      cntQ   <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
    end
  end

  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    unique case (stateQ)
      StIdle: begin
        if (anyReq) begin
          if (LATENCY == 0) begin
            stateD = StDone;
          end else begin
            stateD = StWait;
            cntD   = CntInit;
          end
        end
      end
      StWait: begin
        if (cntQ == 4'd0) stateD = StDone;
        else              cntD   = cntQ - 4'd1;
      end
      StDone:  stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  always_comb begin
    bus.MemStall       = reset & ((inIdle & anyReq) | (stateQ == StWait));
    bus.MemDone        = stateQ == StDone;
    bus.MisalignErr    = (stateQ == StDone) & rejQ;
    bus.MemReadDataOut = rdataQ;
  end

  assign access = reset && (stateQ != StDone) && (stateD == StDone);

  always_ff @(posedge clk) begin
    if (inIdle && anyReq) begin
      addrQ  <= addrEff;
      opQ    <= opEff;
      wdataQ <= wdataEff;
      writeQ <= writeEff;
      rejQ   <= rejEff;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rdataQ <= '0;
    end else if (access) begin
      if (rejEff)         rdataQ <= '0;
      else if (!writeEff) rdataQ <= rdataExt;
    end
  end

  assign rword = mem[addrEff[IdxW+1:2]];

  always_ff @(posedge clk) begin
    if (access && writeEff && !rejEff) begin
      for (int b = 0; b < 4; b++) begin
        if (laneMask[b]) mem[addrEff[IdxW+1:2]][8*b +: 8] <= wdataRep[8*b +: 8];
      end
    end
  end

  dmem_lane_align u_lane_align (
    .op       (opEff),
    .a        (addrEff[1:0]),
    .wdata    (wdataEff),
    .rword    (rword),
    .laneMask (laneMask),
    .wdataRep (wdataRep),
    .rdataExt (rdataExt)
  );

endmodule
